// File: rtl/udp_tx_framer_if.sv
// FrameL2_Out transmit channel: request/grant handshake plus the framed byte stream.
interface udp_tx_framer_if;
  logic       ReqOut;
  logic       ReqConfirm;
  logic       ValOut;
  logic       SoFOut;
  logic       EoFOut;
  logic [7:0] DataOut;

  modport master (output ReqOut, ValOut, SoFOut, EoFOut, DataOut, input ReqConfirm);
  modport slave  (input ReqOut, ValOut, SoFOut, EoFOut, DataOut, output ReqConfirm);
endinterface

// File: rtl/udp_tx_framer.sv
// Ethernet II + IPv4 + UDP transmit framer: FWFT payload in, FrameL2_Out byte stream out.
// Define UDP_TX_PAD_EN to zero-pad frames shorter than 60 bytes.
module udp_tx_framer #(
  parameter int unsigned MAX_LEN = 1472,
  parameter logic [7:0]  TTL     = 8'h40
) (
  input  logic        Clk,
  input  logic        nRst,
  input  logic        Start,
  input  logic [10:0] Len,
  input  logic [47:0] LocalMAC,
  input  logic [47:0] RemoteMAC,
  input  logic [31:0] LocalIP,
  input  logic [31:0] RemoteIP,
  input  logic [15:0] LocalPort,
  input  logic [15:0] RemotePort,
  input  logic        MODE,
  input  logic [7:0]  PayData,
  output logic        PayRd,
  output logic        Busy,
  output logic        StartErr,
  udp_tx_framer_if.master l2
);

  typedef enum logic [2:0] {IDLE, CSUM, REQ, HDR, PAY, PAD, GAP} state_t;
  state_t state, nextState;

  logic [10:0] cnt;
  logic        phase, modeR, startErrR;
  logic [15:0] ipId;
  logic [10:0] lenR;
  logic [47:0] localMacR, remoteMacR;
  logic [31:0] localIpR, remoteIpR, acc;
  logic [15:0] localPortR, remotePortR, csum;
  logic [7:0]  dataHold;

  logic            lenOk, emit, lastPay, padNeeded, eofNow;
  logic [15:0]     ipLen, udpLen, csumWord;
  logic [0:41][7:0] hdrVec;

  // Accumulator is below 2^20 after ten words, so two folds always suffice.
  function automatic logic [15:0] foldInvert(input logic [31:0] a);
    logic [16:0] s1;
    logic [15:0] s2;
    s1 = {1'b0, a[31:16]} + {1'b0, a[15:0]};
    s2 = s1[15:0] + {15'd0, s1[16]};
    return ~s2;
  endfunction

  assign lenOk   = (Len != 11'd0) && (32'(Len) <= MAX_LEN);
  assign emit    = modeR | ~phase;
  assign lastPay = (cnt == lenR - 11'd1);
  assign ipLen   = 16'd28 + {5'd0, lenR};
  assign udpLen  = 16'd8 + {5'd0, lenR};
`ifdef UDP_TX_PAD_EN
  assign padNeeded = (lenR < 11'd18);
`else
  assign padNeeded = 1'b0;
`endif
  assign eofNow = emit && (((state == PAY) && lastPay && !padNeeded) ||
                           ((state == PAD) && (cnt == 11'd17)));

  assign hdrVec = {remoteMacR, localMacR, 16'h0800,
                   16'h4500, ipLen, ipId, 16'h4000, TTL, 8'h11, csum, localIpR, remoteIpR,
                   localPortR, remotePortR, udpLen, 16'h0000};

  always_comb begin
    case (cnt[3:0])
      4'd0:    csumWord = 16'h4500;
      4'd1:    csumWord = ipLen;
      4'd2:    csumWord = ipId;
      4'd3:    csumWord = 16'h4000;
      4'd4:    csumWord = {TTL, 8'h11};
      4'd6:    csumWord = localIpR[31:16];
      4'd7:    csumWord = localIpR[15:0];
      4'd8:    csumWord = remoteIpR[31:16];
      4'd9:    csumWord = remoteIpR[15:0];
      default: csumWord = 16'h0000;
    endcase
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start && lenOk) nextState = CSUM;
      CSUM:    if (cnt == 11'd10) nextState = REQ;
      REQ:     if (l2.ReqConfirm) nextState = HDR;
      HDR:     if (emit && (cnt == 11'd41)) nextState = PAY;
      PAY:     if (emit && lastPay) nextState = padNeeded ? PAD : GAP;
      PAD:     if (emit && (cnt == 11'd17)) nextState = GAP;
      GAP:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // PAD keeps counting from Len so the last pad byte is always index 17.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      cnt       <= '0;
      phase     <= 1'b0;
      modeR     <= 1'b0;
      ipId      <= '0;
      startErrR <= 1'b0;
    end else begin
      startErrR <= (state == IDLE) && Start && !lenOk;
      phase     <= (state == REQ) ? 1'b0 : ~phase;
      if ((state == REQ) && l2.ReqConfirm) modeR <= MODE;
      if (eofNow) ipId <= ipId + 16'd1;
      case (state)
        CSUM:     cnt <= (cnt == 11'd10) ? '0 : cnt + 11'd1;
        HDR:      if (emit) cnt <= (cnt == 11'd41) ? '0 : cnt + 11'd1;
        PAY, PAD: if (emit) cnt <= cnt + 11'd1;
        default:  cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if ((state == IDLE) && Start && lenOk) begin
      lenR        <= Len;
      localMacR   <= LocalMAC;
      remoteMacR  <= RemoteMAC;
      localIpR    <= LocalIP;
      remoteIpR   <= RemoteIP;
      localPortR  <= LocalPort;
      remotePortR <= RemotePort;
      acc         <= '0;
    end else if (state == CSUM) begin
      if (cnt == 11'd10) csum <= foldInvert(acc);
      else               acc  <= acc + {16'd0, csumWord};
    end
    if (l2.ValOut) dataHold <= l2.DataOut;
  end

  // In 10/100 mode the idle half-cycle repeats the previous byte.
  always_comb begin
    Busy       = (state != IDLE);
    StartErr   = startErrR;
    PayRd      = 1'b0;
    l2.ReqOut  = (state == REQ);
    l2.ValOut  = 1'b0;
    l2.SoFOut  = 1'b0;
    l2.EoFOut  = 1'b0;
    l2.DataOut = 8'h00;
    case (state)
      HDR: begin
        l2.ValOut  = emit;
        l2.SoFOut  = emit && (cnt == 11'd0);
        l2.DataOut = emit ? hdrVec[cnt[5:0]] : dataHold;
      end
      PAY: begin
        l2.ValOut  = emit;
        PayRd      = emit;
        l2.EoFOut  = eofNow;
        l2.DataOut = emit ? PayData : dataHold;
      end
      PAD: begin
        l2.ValOut  = emit;
        l2.EoFOut  = eofNow;
        l2.DataOut = emit ? 8'h00 : dataHold;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Randomized bench for udp_tx_framer against a frame-level reference model.
module tb_udp_tx_framer;
  localparam int MAX_LEN = 1472;

  logic        Clk = 1'b0;
  logic        nRst = 1'b0;
  logic        Start = 1'b0;
  logic [10:0] Len = '0;
  logic [47:0] LocalMAC = '0, RemoteMAC = '0;
  logic [31:0] LocalIP = '0, RemoteIP = '0;
  logic [15:0] LocalPort = '0, RemotePort = '0;
  logic        MODE = 1'b0;
  logic [7:0]  PayData;
  logic        PayRd, Busy, StartErr;

  udp_tx_framer_if l2If();

  udp_tx_framer dut (
    .Clk(Clk), .nRst(nRst), .Start(Start), .Len(Len),
    .LocalMAC(LocalMAC), .RemoteMAC(RemoteMAC), .LocalIP(LocalIP), .RemoteIP(RemoteIP),
    .LocalPort(LocalPort), .RemotePort(RemotePort), .MODE(MODE),
    .PayData(PayData), .PayRd(PayRd), .Busy(Busy), .StartErr(StartErr),
    .l2(l2If.master)
  );

  always #4 Clk = ~Clk;

  // FWFT payload source
  logic [7:0]  payBuf [0:2047];
  logic [10:0] payPtr = '0;
  logic        payClr = 1'b0;
  always @(posedge Clk) payPtr <= payClr ? 11'd0 : (PayRd ? payPtr + 11'd1 : payPtr);
  assign PayData = payBuf[payPtr];

  int checks = 0;
  int errors = 0;
  logic [15:0] expId = 16'd0;
  logic [10:0] fLen;
  logic [47:0] fLmac, fRmac;
  logic [31:0] fLip, fRip;
  logic [15:0] fLport, fRport;
  logic [7:0]  expQ[$];
  logic [7:0]  got[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushBytes(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) expQ.push_back(v[8*i +: 8]);
  endtask

  task automatic modelFrame();
    int words[10];
    int sum;
    int ipLen;
    int udpLen;
    logic [15:0] ck;
    ipLen  = 28 + int'(fLen);
    udpLen = 8 + int'(fLen);
    words = '{'h4500, ipLen, int'(expId), 'h4000, 'h4011, 0,
              int'(fLip[31:16]), int'(fLip[15:0]), int'(fRip[31:16]), int'(fRip[15:0])};
    sum = 0;
    foreach (words[i]) sum += words[i];
    while (sum > 'hFFFF) sum = (sum & 'hFFFF) + (sum >>> 16);
    ck = 16'(~sum);
    expQ.delete();
    pushBytes(fRmac, 6);
    pushBytes(fLmac, 6);
    pushBytes(48'h0800, 2);
    pushBytes(48'h4500, 2);
    pushBytes(48'(ipLen), 2);
    pushBytes({32'd0, expId}, 2);
    pushBytes(48'h4000, 2);
    pushBytes(48'h4011, 2);
    pushBytes({32'd0, ck}, 2);
    pushBytes({16'd0, fLip}, 4);
    pushBytes({16'd0, fRip}, 4);
    pushBytes({32'd0, fLport}, 2);
    pushBytes({32'd0, fRport}, 2);
    pushBytes(48'(udpLen), 2);
    pushBytes(48'h0, 2);
    for (int i = 0; i < int'(fLen); i++) expQ.push_back(payBuf[i]);
`ifdef UDP_TX_PAD_EN
    while (expQ.size() < 60) expQ.push_back(8'h00);
`endif
  endtask

  task automatic runFrame(input int len, input bit mode, input int grantDly, input bit gapStart,
                          input int abortAt, input bit dirIp, input int expCk);
    int sofCnt, sofIdx, eofCnt, eofIdx, rdCnt, rdBad, stray, holdBad;
    int reqCyc, csumCyc, gapBusy, errPulses, firstVal, lastVal, idleBad;
    bit done, aborted, gapDriven;
    sofCnt = 0; sofIdx = -1; eofCnt = 0; eofIdx = -1; rdCnt = 0; rdBad = 0; stray = 0;
    holdBad = 0; reqCyc = 0; csumCyc = 0; gapBusy = 0; errPulses = 0; firstVal = -1;
    lastVal = -1; idleBad = 0; done = 0; aborted = 0; gapDriven = 0;

    fLen   = 11'(len);
    fLmac  = {16'($urandom), $urandom};
    fRmac  = {16'($urandom), $urandom};
    fLip   = dirIp ? 32'hC0A80001 : $urandom;
    fRip   = dirIp ? 32'hC0A800C7 : $urandom;
    fLport = 16'($urandom);
    fRport = 16'($urandom);
    for (int i = 0; i < len; i++) payBuf[i] = 8'($urandom);
    modelFrame();
    got.delete();

    @(negedge Clk);
    Start = 1'b1; Len = fLen; MODE = mode; payClr = 1'b1;
    LocalMAC = fLmac; RemoteMAC = fRmac; LocalIP = fLip; RemoteIP = fRip;
    LocalPort = fLport; RemotePort = fRport;

    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge Clk);
      Start = 1'b0;
      payClr = 1'b0;
      if (cyc == 0) begin
        Len = 11'($urandom); LocalMAC = {16'($urandom), $urandom}; RemoteMAC = ~RemoteMAC;
        LocalIP = $urandom; RemoteIP = $urandom; LocalPort = 16'($urandom); RemotePort = ~RemotePort;
      end
      if (StartErr) errPulses++;
      if (!Busy) done = 1'b1;
      else begin
        if (!l2If.ReqOut && !l2If.ValOut && got.size() == 0) csumCyc++;
        if (l2If.ReqOut) begin
          reqCyc++;
          l2If.ReqConfirm = (reqCyc > grantDly);
        end else l2If.ReqConfirm = 1'($urandom);
        if (PayRd) rdCnt++;
        if (PayRd && !l2If.ValOut) rdBad++;
        if ((l2If.SoFOut || l2If.EoFOut) && !l2If.ValOut) stray++;
        if (l2If.ValOut) begin
          if (got.size() == 0) MODE = 1'($urandom);
          got.push_back(l2If.DataOut);
          if (firstVal < 0) firstVal = cyc;
          lastVal = cyc;
          if (l2If.SoFOut) begin sofCnt++; sofIdx = got.size() - 1; end
          if (l2If.EoFOut) begin eofCnt++; eofIdx = got.size() - 1; end
        end else if (eofCnt > 0) begin
          gapBusy++;
          if (gapStart && !gapDriven) begin Start = 1'b1; Len = 11'd0; gapDriven = 1'b1; end
        end else if (got.size() > 0) begin
          if (l2If.DataOut !== got[got.size()-1]) holdBad++;
        end
        if (abortAt >= 0 && PayRd && rdCnt == abortAt + 1) begin
          nRst = 1'b0;
          #1;
          chk("reset_in_pay_outputs",
              {Busy, StartErr, PayRd, l2If.ReqOut, l2If.ValOut, l2If.SoFOut, l2If.EoFOut, l2If.DataOut}, 0);
          aborted = 1'b1;
          done = 1'b1;
        end
      end
    end
    l2If.ReqConfirm = 1'b0;
    Start = 1'b0;
    chk("frame_done", done, 1);

    if (aborted) begin
      @(negedge Clk);
      nRst = 1'b1;
      expId = 16'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        @(negedge Clk);
        if (Busy || StartErr) idleBad++;
      end
      chk("frame_len", got.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < got.size(); i++)
        chk($sformatf("byte%0d_len%0d", i, len), got[i], expQ[i]);
      chk("sof_count", sofCnt, 1);
      chk("sof_index", sofIdx, 0);
      chk("eof_count", eofCnt, 1);
      chk("eof_index", eofIdx, expQ.size() - 1);
      chk("payrd_count", rdCnt, len);
      chk("payrd_without_val", rdBad, 0);
      chk("sof_eof_without_val", stray, 0);
      chk("data_hold", holdBad, 0);
      chk("req_cycles", reqCyc, grantDly + 1);
      chk("csum_cycles", csumCyc, 11);
      chk("gap_cycles", gapBusy, 1);
      chk("starterr_during_frame", errPulses, 0);
      chk("idle_after_frame", idleBad, 0);
      chk("val_span", lastVal - firstVal + 1, mode ? expQ.size() : 2 * expQ.size() - 1);
      if (expCk >= 0 && got.size() > 25) chk("ip_checksum", {got[24], got[25]}, expCk);
      expId = expId + 16'd1;
    end
  endtask

  task automatic rejectStart(input logic [10:0] len);
    int pulses;
    int busyHits;
    pulses = 0;
    busyHits = 0;
    @(negedge Clk);
    Start = 1'b1;
    Len = len;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (StartErr) pulses++;
      if (Busy || l2If.ReqOut) busyHits++;
    end
    chk($sformatf("starterr_pulses_len%0d", len), pulses, 1);
    chk($sformatf("busy_after_reject_len%0d", len), busyHits, 0);
  endtask

  initial begin
    l2If.ReqConfirm = 1'b0;
    for (int i = 0; i < 2048; i++) payBuf[i] = 8'h00;
    repeat (3) @(negedge Clk);
    chk("reset_outputs",
        {Busy, StartErr, PayRd, l2If.ReqOut, l2If.ValOut, l2If.SoFOut, l2If.EoFOut, l2If.DataOut}, 0);
    nRst = 1'b1;
    @(negedge Clk);

    runFrame(87, 1'b1, 3, 1'b0, -1, 1'b1, 'hB861);
    if (got.size() > 19) chk("first_ip_len", {got[16], got[17]}, 16'h0073);
    if (got.size() > 19) chk("first_ip_id", {got[18], got[19]}, 16'h0000);
    runFrame(87, 1'b1, 3, 1'b0, -1, 1'b1, 'hB860);
    if (got.size() > 19) chk("second_ip_id", {got[18], got[19]}, 16'h0001);

    runFrame(4, 1'b1, 0, 1'b0, -1, 1'b0, -1);
    if (got.size() > 17) chk("short_ip_len", {got[16], got[17]}, 16'h0020);
`ifdef UDP_TX_PAD_EN
    chk("short_frame_bytes", got.size(), 60);
`else
    chk("short_frame_bytes", got.size(), 46);
`endif

    rejectStart(11'd0);
    rejectStart(11'(MAX_LEN + 1));
    rejectStart(11'($urandom_range(MAX_LEN + 2, 2047)));

    runFrame(18, 1'b0, 2, 1'b1, -1, 1'b0, -1);
    chk("mode0_frame_bytes", got.size(), 60);

    runFrame(100, 1'b1, 1, 1'b0, 10, 1'b0, -1);
    runFrame(50, 1'b1, 0, 1'b0, -1, 1'b0, -1);
    if (got.size() > 19) chk("ip_id_after_reset", {got[18], got[19]}, 16'h0000);

    runFrame(1, 1'b0, 4, 1'b1, -1, 1'b0, -1);
    runFrame(MAX_LEN, 1'b1, 2, 1'b0, -1, 1'b0, -1);

    for (int k = 0; k < 10; k++)
      runFrame(int'($urandom_range(1, 120)), 1'($urandom), int'($urandom_range(0, 5)),
               1'($urandom), -1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/udp_tx_framer.md
Name: udp_tx_framer

Overview:
- Transmit-direction counterpart of the FrameSync/FrameL3/FrameL4 receive chain.
- Takes a UDP payload from a first-word-fall-through (FWFT) byte source and emits a complete Ethernet II + IPv4 + UDP frame as a byte stream. The frame has no preamble and no FCS.
- Output attaches to a FrameL2_Out input channel (Val/SoF/EoF/Req/Data) and uses the per-channel ReqConfirm grant.
- The IPv4 header checksum is computed in hardware before the frame is requested.

Parameters:
- MAX_LEN, 1472: maximum accepted payload length in bytes.
- TTL, 8'h40: IPv4 time-to-live field.

Ports:
- Clk  in  1  system clock (clk125 domain).
- nRst  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request to send one frame; sampled only in IDLE.
- Len  in  11  payload byte count, latched on accepted Start.
- LocalMAC  in  48  source MAC, latched on Start.
- RemoteMAC  in  48  destination MAC, latched on Start.
- LocalIP  in  32  source IP, latched on Start.
- RemoteIP  in  32  destination IP, latched on Start.
- LocalPort  in  16  UDP source port, latched on Start.
- RemotePort  in  16  UDP destination port, latched on Start.
- MODE  in  1  1 = gigabit (one byte per clock); 0 = 10/100 (one byte per two clocks).
- PayData  in  8  FWFT payload byte, valid whenever the source is non-empty.
- PayRd  out  1  consumes the current PayData byte.
- ReqConfirm  in  1  grant from FrameL2_Out.
- ReqOut  out  1  transmit request to FrameL2_Out.
- ValOut  out  1  DataOut valid.
- SoFOut  out  1  first frame byte.
- EoFOut  out  1  last frame byte.
- DataOut  out  8  frame byte.
- Busy  out  1  high in every state except IDLE.
- StartErr  out  1  one-cycle pulse when Start is rejected.

Behaviour:
- Reset (nRst low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0.
  - IP identification counter IpId goes to 0.
  - A frame in progress is abandoned with no EoFOut.
- States: IDLE, CSUM, REQ, HDR, PAY, PAD, GAP.
- IDLE:
  - Start with 1<=Len<=MAX_LEN: latch all inputs, clear accumulator, go to CSUM.
  - Start with Len==0 or Len>MAX_LEN: StartErr pulses 1 cycle, state stays IDLE, nothing else changes.
- CSUM (11 cycles):
  - Cycles 1-10 each add one 16-bit header word into a 32-bit accumulator. The checksum field counts as 0 for this sum.
  - Word order: 4500, 28+Len, IpId, 4000, {TTL,8'h11}, 0, LocalIP[31:16], LocalIP[15:0], RemoteIP[31:16], RemoteIP[15:0].
  - Cycle 11: fold carries twice, invert, store the result as Csum. Then go to REQ.
- REQ:
  - ReqOut is held high until ReqConfirm is sampled high.
  - ReqOut deasserts in the next cycle; state goes to HDR.
  - ReqConfirm seen in any other state is ignored.
- Byte emission timing:
  - MODE=1: ValOut is high every cycle in HDR/PAY/PAD.
  - MODE=0: ValOut is high on alternate cycles, starting with the first HDR cycle. DataOut holds its value across the idle cycle.
  - MODE is sampled once per frame, at REQ exit.
- HDR emits 42 bytes, MSB first:
  - RemoteMAC (6), LocalMAC (6), 08 00.
  - IPv4 header, 20 bytes, with Csum inserted at bytes 24-25.
  - LocalPort, RemotePort, UDP length = 8+Len, UDP checksum 0000.
  - SoFOut is high with byte 0 only.
- PAY:
  - Emits Len bytes; DataOut = PayData.
  - PayRd pulses in the same cycle as each ValOut. Exactly Len pulses per frame.
  - The source must never be empty in PAY (caller's contract). This block does not check it.
- EoFOut is high with the last byte of PAY, or of PAD when padding is applied.
- After EoFOut:
  - IpId increments by 1; it wraps FFFF to 0000.
  - State goes to GAP for 1 cycle, then IDLE.
  - Start during GAP is ignored; no StartErr pulse.
- Width rules: 28+Len and 8+Len are 16-bit zero-extended sums. The byte counter is 11 bits.

Optional Feature:
- Macro: UDP_TX_PAD_EN.
- Defined: when 42+Len<60, PAD emits (18-Len) bytes of 00 after the payload, so the frame is exactly 60 bytes. EoFOut moves to the last pad byte. IP and UDP length fields are unchanged.
- Undefined: PAD state is unreachable; EoFOut is always on the last payload byte. Minimum frame length is left to FrameL2_Out.

Test Plan:
- First frame after reset: Len=87, LocalIP=C0A80001, RemoteIP=C0A800C7, MODE=1, grant 3 cycles after ReqOut -> header bytes 16-17 = 0073, bytes 18-19 = 0000, bytes 24-25 = B861; 129 ValOut cycles; SoFOut on the first, EoFOut on the last; 87 PayRd pulses.
- Second frame, same inputs -> IP ID = 0001; checksum = B860.
- Len=4, UDP_TX_PAD_EN defined -> 60 bytes total, bytes 46-59 = 00, IP total length 0020. Macro undefined -> 46 bytes, EoFOut on byte 45.
- Len=0 and Len=1473 -> one StartErr pulse each; Busy and ReqOut stay 0.
- MODE=0, Len=18 -> ValOut toggles for 120 cycles and delivers 60 bytes; PayRd pulses only on ValOut cycles.
- nRst low during PAY byte 10 -> all outputs 0 immediately. A new Start after release produces a complete frame with IP ID 0000.
